// File: rtl/ica_pkg.sv
// Shared constants and types for the ICA reconstruction blocks.
package ica_pkg;

   // Default number of fractional bits in fixed-point eigenvector entries.
   localparam int FRAC_BITS = 8;

   // Control states of the unwhiten sequencer.
   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MAC,
      WRITE,
      DONE
   } unwhiten_state_t;

endpackage : ica_pkg

// File: rtl/mac_unit.sv
// Registered signed 32x32->64 multiply-accumulate.
// clr has priority over en; both are synchronous. rst is async active-low.
module mac_unit (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en,
   input  logic signed [31:0] a,
   input  logic signed [31:0] b,
   output logic signed [63:0] acc
);

   logic signed [63:0] prod;

   // Sign-extend both operands before multiplying so the full product fits.
   assign prod = 64'(a) * 64'(b);

   // Accumulator register: clear or add one product per enabled cycle.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     acc <= '0;
      else if (clr) acc <= '0;
      else if (en)  acc <= acc + prod;
   end

endmodule : mac_unit

// File: rtl/unwhiten.sv
// unwhiten: reconstructs D = (T^T * U) >>> FRAC_BITS one element at a time,
// using a single MAC unit. Each output element takes SIZE_A MAC cycles plus
// one WRITE cycle.
// Optional feature: define UNWHITEN_MEAN_EN to add a per-row mean port whose
// value is added to every reconstructed element of that row.
module unwhiten #(
   parameter int SIZE_A    = 8,
   parameter int SIZE_B    = 8,
   parameter int FRAC_BITS = ica_pkg::FRAC_BITS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic signed [31:0] eigvec_t [SIZE_A][SIZE_A],
   input  logic signed [31:0] mat      [SIZE_A][SIZE_B],
`ifdef UNWHITEN_MEAN_EN
   input  logic signed [31:0] mean     [SIZE_A],
`endif
   output logic               busy,
   output logic               done,
   output logic signed [31:0] mat_out  [SIZE_A][SIZE_B]
);

   import ica_pkg::*;

   localparam int IW_A = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
   localparam int IW_B = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;

   unwhiten_state_t state_q, state_d;

   logic [IW_A-1:0] idx_i, idx_k;
   logic [IW_B-1:0] idx_j;

   // Operand snapshots taken in LOAD so later input changes are ignored.
   logic signed [31:0] t_reg [SIZE_A][SIZE_A];
   logic signed [31:0] u_reg [SIZE_A][SIZE_B];
`ifdef UNWHITEN_MEAN_EN
   logic signed [31:0] mean_reg [SIZE_A];
`endif

   logic               last_i, last_j, last_k;
   logic               mac_clr, mac_en;
   logic signed [31:0] mac_a, mac_b;
   logic signed [63:0] acc;
   logic signed [31:0] scaled;
   logic signed [31:0] wr_val;

   assign last_i = (idx_i == IW_A'(SIZE_A - 1));
   assign last_j = (idx_j == IW_B'(SIZE_B - 1));
   assign last_k = (idx_k == IW_A'(SIZE_A - 1));

   // Element (i,j) of D uses column i of T, i.e. T[k][i], against U[k][j].
   assign mac_a   = t_reg[idx_k][idx_i];
   assign mac_b   = u_reg[idx_k][idx_j];
   assign mac_en  = (state_q == MAC);
   assign mac_clr = (state_q == LOAD) || (state_q == WRITE);

   // Arithmetic shift floors toward -inf; the cast keeps the low 32 bits.
   assign scaled = 32'(acc >>> FRAC_BITS);

`ifdef UNWHITEN_MEAN_EN
   assign wr_val = scaled + mean_reg[idx_i];
`else
   assign wr_val = scaled;
`endif

   mac_unit u_mac (
      .clk (clk),
      .rst (rst),
      .clr (mac_clr),
      .en  (mac_en),
      .a   (mac_a),
      .b   (mac_b),
      .acc (acc)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state decode and status outputs.
   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      busy    = 1'b1;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) state_d = LOAD;
         end
         LOAD:  state_d = MAC;
         MAC:   if (last_k) state_d = WRITE;
         WRITE: state_d = (last_i && last_j) ? DONE : MAC;
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Operand capture on LOAD.
   // NOTE: these snapshot arrays carry no reset; they are always rewritten in
   // LOAD before any MAC reads them, so resetting them would only cost logic.
   always_ff @(posedge clk) begin
      if (state_q == LOAD) begin
         t_reg <= eigvec_t;
         u_reg <= mat;
`ifdef UNWHITEN_MEAN_EN
         mean_reg <= mean;
`endif
      end
   end

   // Index sequencing (k innermost, then j, then i) and result write-back.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_i <= '0;
         idx_j <= '0;
         idx_k <= '0;
         for (int r = 0; r < SIZE_A; r++) begin
            for (int c = 0; c < SIZE_B; c++) begin
               mat_out[r][c] <= '0;
            end
         end
      end else begin
         case (state_q)
            LOAD: begin
               idx_i <= '0;
               idx_j <= '0;
               idx_k <= '0;
            end
            MAC: idx_k <= last_k ? '0 : idx_k + 1'b1;
            WRITE: begin
               mat_out[idx_i][idx_j] <= wr_val;
               if (last_j) begin
                  idx_j <= '0;
                  idx_i <= last_i ? '0 : idx_i + 1'b1;
               end else begin
                  idx_j <= idx_j + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule : unwhiten

// File: doc/unwhiten.md
UNWHITEN -- requirements
Module: unwhiten

Interface
REQ-001 Parameter SIZE_A, default 8, meaning: number of channels, i.e. rows of the projected and reconstructed matrices.
REQ-002 Parameter SIZE_B, default 8, meaning: number of samples, i.e. columns.
REQ-003 Parameter FRAC_BITS, default ica_pkg::FRAC_BITS (8), meaning: fractional bits of the eigenvector entries.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin reconstruction.
REQ-007 eigvec_t  input  integer[SIZE_A][SIZE_A]  transposed eigenvector matrix T, Q(31-FRAC_BITS).FRAC_BITS.
REQ-008 mat  input  integer[SIZE_A][SIZE_B]  projected data U.
REQ-009 mean  input  integer[SIZE_A]  per-row mean; port present only when UNWHITEN_MEAN_EN is defined.
REQ-010 busy  output  1  high from the cycle after start is accepted until done.
REQ-011 done  output  1  one-cycle pulse when mat_out is valid.
REQ-012 mat_out  output  integer[SIZE_A][SIZE_B]  reconstructed data D.

Function
REQ-013 mat_out[i][j] SHALL equal (sum over k of T[k][i]*U[k][j]) >>> FRAC_BITS, truncated to 32 bits.
- Products and the sum use a 64-bit signed accumulator.
- The shift is arithmetic (floor).
REQ-014 The FSM SHALL have states IDLE, LOAD, MAC, WRITE and DONE.
REQ-015 IDLE with start=1 SHALL go to LOAD; start in any other state SHALL be ignored.
REQ-016 LOAD, one cycle: SHALL capture eigvec_t, mat and mean into internal registers, clear the accumulator, set i=j=k=0.
- Input changes after LOAD have no effect on the current operation.
REQ-017 MAC SHALL perform exactly one multiply-accumulate per cycle for k=0..SIZE_A-1, then go to WRITE.
REQ-018 WRITE, one cycle: SHALL store the shifted result into mat_out[i][j] and clear the accumulator.
- Indices advance j-fastest, then i.
- Next state is MAC, or DONE after element (SIZE_A-1,SIZE_B-1).
REQ-019 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-020 With start sampled in cycle 0, done SHALL be high in cycle 2+SIZE_A*SIZE_B*(SIZE_A+1); busy SHALL be high in cycles 1 through that cycle.
REQ-021 mat_out elements SHALL hold their last written value until overwritten or reset.
- Elements not yet written in the current run keep their prior-run values.
REQ-022 start asserted in the DONE cycle SHALL be ignored; a new run requires start in IDLE.

Reset
REQ-023 rst=0 SHALL immediately force: state IDLE, busy=0, done=0, all mat_out elements 0, accumulator and indices 0.
REQ-024 Reset mid-operation SHALL abort the run with no done pulse; the first start after reset release begins a full new run.

Configuration
REQ-025 With UNWHITEN_MEAN_EN defined: the mean port SHALL exist, and WRITE SHALL store the shifted result plus mean[i] (32-bit wrap).
REQ-026 Without UNWHITEN_MEAN_EN: there SHALL be no mean port and no mean register; the result is per REQ-013 only.

Structure
REQ-027 Package ica_pkg SHALL hold the FRAC_BITS default constant and the state enum typedef unwhiten_state_t.
REQ-028 A single sub-module mac_unit SHALL be used.
- Registered 32x32->64 signed multiply-add with clear and enable.
- One instance.

Verification (SIZE_A=2, SIZE_B=2, FRAC_BITS=8)
REQ-029 T=[[256,0],[0,256]], U=[[1,2],[3,4]], start at cycle 0 -> done only in cycle 14, mat_out=[[1,2],[3,4]], busy cycles 1-14.
REQ-030 T=[[0,256],[256,0]], U=[[1,2],[3,4]] -> mat_out=[[3,4],[1,2]].
REQ-031 T=[[128,0],[0,128]], U=[[3,-3],[-1,0]] -> mat_out=[[1,-2],[-1,0]] (floor shift).
REQ-032 Run REQ-029 with start held high throughout, and U changed to all 9 in cycle 5 -> single done at cycle 14, result unchanged, new run begins only after IDLE.
REQ-033 rst=0 in cycle 7 of a run -> busy, done and mat_out go to 0 immediately, no done pulse; a new start after release completes normally.
REQ-034 With UNWHITEN_MEAN_EN, stimulus of REQ-029 plus mean=[10,-10] -> mat_out=[[11,12],[-7,-6]].
